// File: rtl/rf_wb_if.sv
// Write-back bus between the two result sources, the issue logic and the register-file
// write port.
interface rf_wb_if;
    logic        a_valid;
    logic        a_ready;
    logic [4:0]  a_reg;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_reg;
    logic [31:0] b_data;
    logic        issue_valid;
    logic [4:0]  issue_reg;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] busy;

    // master: the sources and the issue logic; slave: the arbiter
    modport master (
        output a_valid, a_reg, a_data,
        output b_valid, b_reg, b_data,
        output issue_valid, issue_reg,
        input  a_ready, b_ready,
        input  rf_we, rf_waddr, rf_wdata, busy
    );

    modport slave (
        input  a_valid, a_reg, a_data,
        input  b_valid, b_reg, b_data,
        input  issue_valid, issue_reg,
        output a_ready, b_ready,
        output rf_we, rf_waddr, rf_wdata, busy
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between the ALU path (A) and the memory/multiply
// path (B). A has fixed priority and B has a starvation guard. Also keeps the busy scoreboard.
module rf_wb_arbiter #(
    parameter int STARVE_LIM = 3
) (
    input  logic    clk,
    input  logic    rst_n,
    rf_wb_if.slave  bus
);

    localparam logic [3:0] LIM = 4'(STARVE_LIM);
    localparam logic [3:0] CNT_MAX = 4'hF;

    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        rf_we_q, rf_we_d;
    logic [4:0]  rf_waddr_q, rf_waddr_d;
    logic [31:0] rf_wdata_q, rf_wdata_d;
    logic [31:0] busy_q, busy_d;

    logic        starve;
    logic        a_ready, b_ready;
    logic        a_xfer, b_xfer;

    // starve comes only from the registered count, so b_ready never depends on b_valid
    assign starve  = (starve_cnt_q >= LIM);
    assign a_ready = !starve;
    assign b_ready = !bus.a_valid || starve;
    assign a_xfer  = bus.a_valid && a_ready;
    assign b_xfer  = bus.b_valid && b_ready;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!bus.b_valid || b_xfer) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q != CNT_MAX) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (a_xfer) begin
            rf_we_d    = (bus.a_reg != 5'd0);
            rf_waddr_d = bus.a_reg;
            rf_wdata_d = bus.a_data;
        end else if (b_xfer) begin
            rf_we_d    = (bus.b_reg != 5'd0);
            rf_waddr_d = bus.b_reg;
            rf_wdata_d = bus.b_data;
        end
    end

    // Clear is applied before set so a new issue to the register being written stays pending
    always_comb begin
        busy_d = busy_q;
        if (rf_we_q) begin
            busy_d[rf_waddr_q] = 1'b0;
        end
        if (bus.issue_valid) begin
            busy_d[bus.issue_reg] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= 4'd0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= 5'd0;
            rf_wdata_q   <= 32'd0;
            busy_q       <= 32'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.a_ready  = a_ready;
    assign bus.b_ready  = b_ready;
    assign bus.rf_we    = rf_we_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed-vector bench for rf_wb_arbiter with STARVE_LIM = 3.
module tb_rf_wb_arbiter;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    rf_wb_if bus ();

    rf_wb_arbiter #(.STARVE_LIM(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.a_valid     = 1'b0;
        bus.a_reg       = 5'd0;
        bus.a_data      = 32'd0;
        bus.b_valid     = 1'b0;
        bus.b_reg       = 5'd0;
        bus.b_data      = 32'd0;
        bus.issue_valid = 1'b0;
        bus.issue_reg   = 5'd0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        chk("idle_a_ready", 32'(bus.a_ready), 32'd1);
        chk("idle_b_ready", 32'(bus.b_ready), 32'd1);
        chk("idle_rf_we",   32'(bus.rf_we),   32'd0);
        chk("idle_busy",    bus.busy,         32'd0);

        // Single A write
        bus.a_valid = 1'b1;
        bus.a_reg   = 5'd5;
        bus.a_data  = 32'hDEADBEEF;
        #1;
        chk("a1_ready", 32'(bus.a_ready), 32'd1);
        step();
        idle();
        #1;
        chk("a1_we",    32'(bus.rf_we),    32'd1);
        chk("a1_waddr", 32'(bus.rf_waddr), 32'd5);
        chk("a1_wdata", bus.rf_wdata,      32'hDEADBEEF);
        step();
        chk("a1_we_off", 32'(bus.rf_we), 32'd0);

        // Starvation: A valid every cycle, B raised in cycle 0
        for (int c = 0; c <= 4; c++) begin
            bus.a_valid = 1'b1;
            bus.a_reg   = 5'(10 + c);
            bus.a_data  = 32'h100 + 32'(c);
            bus.b_valid = (c <= 3);
            bus.b_reg   = 5'd7;
            bus.b_data  = 32'h1234;
            #1;
            chk($sformatf("st%0d_a_ready", c), 32'(bus.a_ready), (c == 3) ? 32'd0 : 32'd1);
            chk($sformatf("st%0d_b_ready", c), 32'(bus.b_ready), (c == 3) ? 32'd1 : 32'd0);
            if (c >= 1) begin
                chk($sformatf("st%0d_waddr", c), 32'(bus.rf_waddr),
                    (c == 4) ? 32'd7 : 32'(10 + c - 1));
                chk($sformatf("st%0d_wdata", c), bus.rf_wdata,
                    (c == 4) ? 32'h1234 : 32'h100 + 32'(c - 1));
            end
            step();
        end
        idle();
        #1;
        chk("st5_waddr", 32'(bus.rf_waddr), 32'd14);
        chk("st5_wdata", bus.rf_wdata,      32'h104);
        step();

        // Register 0 write and issue
        bus.a_valid = 1'b1;
        bus.a_reg   = 5'd0;
        bus.a_data  = 32'hFFFFFFFF;
        #1;
        chk("r0_ready", 32'(bus.a_ready), 32'd1);
        step();
        idle();
        bus.issue_valid = 1'b1;
        bus.issue_reg   = 5'd0;
        #1;
        chk("r0_we",    32'(bus.rf_we),    32'd0);
        chk("r0_waddr", 32'(bus.rf_waddr), 32'd0);
        step();
        idle();
        #1;
        chk("r0_busy", bus.busy, 32'd0);

        // Scoreboard set then clear via a B write
        bus.issue_valid = 1'b1;
        bus.issue_reg   = 5'd9;
        step();
        idle();
        #1;
        chk("sb_set", bus.busy, 32'h0000_0200);
        bus.b_valid = 1'b1;
        bus.b_reg   = 5'd9;
        bus.b_data  = 32'hCAFE0009;
        #1;
        chk("sb_b_ready", 32'(bus.b_ready), 32'd1);
        step();
        idle();
        #1;
        chk("sb_we",         32'(bus.rf_we),    32'd1);
        chk("sb_waddr",      32'(bus.rf_waddr), 32'd9);
        chk("sb_busy_still", bus.busy,          32'h0000_0200);
        step();
        chk("sb_clear", bus.busy, 32'd0);

        // Set/clear collision on reg 9, plus an unrelated issue to reg 4
        bus.issue_valid = 1'b1;
        bus.issue_reg   = 5'd9;
        step();
        idle();
        bus.b_valid = 1'b1;
        bus.b_reg   = 5'd9;
        bus.b_data  = 32'h99;
        step();
        idle();
        bus.issue_valid = 1'b1;
        bus.issue_reg   = 5'd9;
        #1;
        chk("col_we",    32'(bus.rf_we),    32'd1);
        chk("col_waddr", 32'(bus.rf_waddr), 32'd9);
        step();
        idle();
        bus.issue_valid = 1'b1;
        bus.issue_reg   = 5'd4;
        step();
        idle();
        #1;
        chk("col_busy", bus.busy, 32'h0000_0210);

        // Mid-stream reset with a write in the output register
        bus.a_valid = 1'b1;
        bus.a_reg   = 5'd3;
        bus.a_data  = 32'hA5A5A5A5;
        step();
        idle();
        #1;
        chk("rst_pre_we", 32'(bus.rf_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_we",    32'(bus.rf_we),    32'd0);
        chk("rst_waddr", 32'(bus.rf_waddr), 32'd0);
        chk("rst_wdata", bus.rf_wdata,      32'd0);
        chk("rst_busy",  bus.busy,          32'd0);
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_a_ready", 32'(bus.a_ready), 32'd1);
        chk("post_b_ready", 32'(bus.b_ready), 32'd1);
        chk("post_we",      32'(bus.rf_we),   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
